division_dispatcher: RTL

//  Upstream sequencer for the fixed-point divider. Buffers operand pairs from a

---
 rtl/division_dispatcher.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/division_dispatcher.sv
// Operand-pair FIFO in front of the fixed-point divider: sequences ld/start one pair at a time and
// returns quotient/overflow, or a local divide-by-zero / timeout result, on a valid/ready port.
module division_dispatcher #(
    parameter int W       = 10,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_a_i,
    input  logic [W-1:0] in_b_i,
    output logic [W-1:0] div_a_o,
    output logic [W-1:0] div_b_o,
    output logic         ld_a_o,
    output logic         ld_b_o,
    output logic         start_o,
    input  logic         div_done_i,
    input  logic [W-1:0] div_q_i,
    input  logic         div_ov_i,
    output logic         res_valid_o,
    input  logic         res_ready_i,
    output logic [W-1:0] res_q_o,
    output logic         res_ov_o,
    output logic         res_dz_o,
    output logic         res_to_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT);

    // state | meaning: IDLE wait for head | LOAD ld strobes | START start strobe | WAIT done or timeout | OUT hold result
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    logic [W-1:0]     mem_a_q [DEPTH];
    logic [W-1:0]     mem_b_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q;
    logic [2:0]       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [W-1:0]     res_q_q, res_q_d;
    logic             res_ov_q, res_ov_d;
    logic             res_dz_q, res_dz_d;
    logic             res_to_q, res_to_d;
    logic             push, pop, empty;
    logic [W-1:0]     head_a, head_b;

    assign empty  = (cnt_q == '0);
    assign push   = in_valid_i && !full_q;
    assign pop    = res_valid_o && res_ready_i;
    assign head_a = mem_a_q[rd_ptr_q];
    assign head_b = mem_b_q[rd_ptr_q];
    assign cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);

    assign in_ready_o  = !full_q;
    assign div_a_o     = empty ? '0 : head_a;
    assign div_b_o     = empty ? '0 : head_b;
    assign ld_a_o      = (state_q == S_LOAD);
    assign ld_b_o      = (state_q == S_LOAD);
    assign start_o     = (state_q == S_START);
    assign res_valid_o = (state_q == S_OUT);
    assign res_q_o     = res_q_q;
    assign res_ov_o    = res_ov_q;
    assign res_dz_o    = res_dz_q;
    assign res_to_o    = res_to_q;

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        res_q_d  = res_q_q;
        res_ov_d = res_ov_q;
        res_dz_d = res_dz_q;
        res_to_d = res_to_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    if (head_b == '0) begin
                        res_q_d  = '1;
                        res_ov_d = 1'b1;
                        res_dz_d = 1'b1;
                        res_to_d = 1'b0;
                        state_d  = S_OUT;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: state_d = S_START;
            S_START: begin
                tmr_d   = TMR_W'(TIMEOUT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // div_done takes priority over a timeout expiring in the same cycle
                if (div_done_i) begin
                    res_q_d  = div_q_i;
                    res_ov_d = div_ov_i;
                    res_dz_d = 1'b0;
                    res_to_d = 1'b0;
                    state_d  = S_OUT;
                end else if (tmr_q == '0) begin
                    res_q_d  = '1;
                    res_ov_d = 1'b1;
                    res_dz_d = 1'b0;
                    res_to_d = 1'b1;
                    state_d  = S_OUT;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_OUT: begin
                if (res_ready_i) begin
                    res_dz_d = 1'b0;
                    res_to_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_a_q[wr_ptr_q] <= in_a_i;
            mem_b_q[wr_ptr_q] <= in_b_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            state_q  <= S_IDLE;
            tmr_q    <= '0;
            res_q_q  <= '0;
            res_ov_q <= 1'b0;
            res_dz_q <= 1'b0;
            res_to_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q    <= cnt_d;
            full_q   <= (cnt_d == CNT_W'(DEPTH));
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            res_q_q  <= res_q_d;
            res_ov_q <= res_ov_d;
            res_dz_q <= res_dz_d;
            res_to_q <= res_to_d;
        end
    end
endmodule
